// File: rtl/pipe_pkg.sv
// pipe_pkg: constants shared by the 5-stage MIPS pipeline and its GRF scoreboard.
//   NREG         number of architectural registers tracked (register 0 never is)
//   T_W          width of the Tnew / Tuse timing fields
//   MAX_INFLIGHT outstanding writes per register (one each in E, M, W)
//   CW           width of the per-register outstanding-write counter
//   TUSE_* / TNEW_* timing classes used by the decoder when building requests
package pipe_pkg;

    localparam int NREG         = 32;
    localparam int T_W          = 2;
    localparam int MAX_INFLIGHT = 3;
    localparam int CW           = $clog2(MAX_INFLIGHT + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Cycles until a source operand is consumed.
    localparam logic [T_W-1:0] TUSE_BR  = T_W'(0);
    localparam logic [T_W-1:0] TUSE_ALU = T_W'(1);
    localparam logic [T_W-1:0] TUSE_ST  = T_W'(2);

    // Cycles until a result becomes forwardable.
    localparam logic [T_W-1:0] TNEW_ALU  = T_W'(1);
    localparam logic [T_W-1:0] TNEW_LD   = T_W'(2);
    localparam logic [T_W-1:0] TNEW_LINK = T_W'(0);

endpackage

// File: rtl/sb_entry.sv
// sb_entry: outstanding-write counter and readiness countdown for one register.
//   clk, reset  clock and synchronous active-high reset
//   inc         an accepted instruction writes this register (also loads tnew)
//   wb_hit      GRF write port targets this register this cycle
//   tnew_in     Tnew of the accepting producer
//   cnt         outstanding writes
//   tnew        cycles until the youngest producer's result is forwardable
module sb_entry
    import pipe_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           inc,
    input  logic           wb_hit,
    input  logic [T_W-1:0] tnew_in,
    output logic [CW-1:0]  cnt,
    output logic [T_W-1:0] tnew
);

    // A write-back with nothing outstanding is ignored so the counter never underflows.
    logic dec;
    assign dec = wb_hit && (cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tnew <= '0;
        end else begin
            if (inc && !dec) begin
                cnt <= cnt + CNT_ONE;
            end else if (dec && !inc) begin
                cnt <= cnt - CNT_ONE;
            end
            // The youngest producer defines readiness, so a load overrides the countdown.
            if (inc) begin
                tnew <= tnew_in;
            end else if (tnew != '0) begin
                tnew <= tnew - T_W'(1);
            end
        end
    end

endmodule

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: issue-side hazard scoreboard for the 32x32 GRF.
//   clk, reset              clock and synchronous active-high reset
//   issue_valid             decode stage holds an instruction
//   rs_addr/rs_tuse         source 1 register and cycles until it is consumed
//   rt_addr/rt_tuse         source 2 register and cycles until it is consumed
//   dst_we/dst_addr/dst_tnew destination write and cycles until forwardable
//   wb_we/wb_addr           GRF write port this cycle (retires one write)
//   stall                   hold decode and insert a bubble
//   issue_fire              instruction accepted this cycle
//   busy_mask               bit r set while register r has an outstanding write
//   stall_cycles            count of stalled cycles (GRF_SB_PERF_EN builds only,
//                           otherwise tied to zero)
//
// Handshake: issue_valid acts as valid and !stall as ready; an instruction is
// accepted (issue_fire) exactly in a cycle where issue_valid=1 and stall=0. The
// decode stage must hold its request unchanged while stall=1.
module grf_scoreboard
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [4:0]      rs_addr,
    input  logic [4:0]      rt_addr,
    input  logic [T_W-1:0]  rs_tuse,
    input  logic [T_W-1:0]  rt_tuse,
    input  logic            dst_we,
    input  logic [4:0]      dst_addr,
    input  logic [T_W-1:0]  dst_tnew,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    output logic            stall,
    output logic            issue_fire,
    output logic [NREG-1:0] busy_mask,
    output logic [31:0]     stall_cycles
);

    logic [CW-1:0]  cnt_a  [NREG];
    logic [T_W-1:0] tnew_a [NREG];
    logic           load_dst;

    // Register 0 is hard-wired to zero and never tracked.
    assign cnt_a[0]  = '0;
    assign tnew_a[0] = '0;

    assign load_dst = issue_fire && dst_we && (dst_addr != 5'd0);

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry u_entry (
            .clk     (clk),
            .reset   (reset),
            .inc     (load_dst && (dst_addr == 5'(r))),
            .wb_hit  (wb_we && (wb_addr == 5'(r))),
            .tnew_in (dst_tnew),
            .cnt     (cnt_a[r]),
            .tnew    (tnew_a[r])
        );
    end

    for (genvar r = 0; r < NREG; r++) begin : g_busy
        assign busy_mask[r] = (cnt_a[r] != '0);
    end

    logic ret_rs, ret_rt, haz_rs, haz_rt, full;

    always_comb begin
        // A source whose last outstanding write lands on the GRF this cycle is
        // served by the GRF's read-during-write bypass, so it is ready.
        ret_rs = wb_we && (wb_addr == rs_addr) && (rs_addr != 5'd0) && (cnt_a[rs_addr] == CNT_ONE);
        ret_rt = wb_we && (wb_addr == rt_addr) && (rt_addr != 5'd0) && (cnt_a[rt_addr] == CNT_ONE);

        haz_rs = (rs_addr != 5'd0) && (cnt_a[rs_addr] != '0) && !ret_rs
                 && (tnew_a[rs_addr] > rs_tuse);
        haz_rt = (rt_addr != 5'd0) && (cnt_a[rt_addr] != '0) && !ret_rt
                 && (tnew_a[rt_addr] > rt_tuse);

        // A retire to the same register frees a slot in the same cycle.
        full = dst_we && (dst_addr != 5'd0) && (cnt_a[dst_addr] == CNT_MAX)
               && !(wb_we && (wb_addr == dst_addr));

        stall      = issue_valid && (haz_rs || haz_rt || full);
        issue_fire = issue_valid && !stall;
    end

`ifdef GRF_SB_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'b0;
`endif

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Issue-side scoreboard for the 32x32 GRF in the 5-stage MIPS pipeline.
- Tracks outstanding writes per architectural register, with a countdown to when each result becomes forwardable.
- Issues a stall to the decode stage when an operand's needed-by time (Tuse) is earlier than the producer's ready time (Tnew).
- Retires entries on the GRF write port. Same-cycle write-through counts as ready, matching GRF read-during-write bypass.

Parameters:
- NREG, 32, number of tracked registers; register 0 is never tracked.
- T_W, 2, width of Tnew/Tuse fields.
- MAX_INFLIGHT, 3, maximum outstanding writes per register (E/M/W); counter width CW = $clog2(MAX_INFLIGHT+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  decode stage holds an instruction
- rs_addr  in  5  source 1 register
- rt_addr  in  5  source 2 register
- rs_tuse  in  T_W  cycles until rs is consumed
- rt_tuse  in  T_W  cycles until rt is consumed
- dst_we  in  1  instruction writes GRF
- dst_addr  in  5  destination register
- dst_tnew  in  T_W  cycles until the result is forwardable
- wb_we  in  1  GRF write port enable this cycle
- wb_addr  in  5  GRF write port address
- stall  out  1  hold decode stage and insert bubble
- issue_fire  out  1  instruction accepted this cycle
- busy_mask  out  NREG  bit r = register r has at least one outstanding write
- stall_cycles  out  32  stall counter (see Optional Feature)

Behaviour:
- Interface: clock clk; reset is synchronous, active-high.
- Per-register state: cnt[r] (CW bits) and tnew[r] (T_W bits). Reset clears all to 0. Register 0 is hard-wired to 0.
- Reset outputs: stall=0, issue_fire=0, busy_mask=0, stall_cycles=0. Outputs are combinational from state and inputs, so reset takes effect the cycle after reset is sampled.
- retire_last(r) = wb_we && wb_addr==r && r!=0 && cnt[r]==1.
- haz_rs = rs_addr!=0 && cnt[rs_addr]!=0 && !retire_last(rs_addr) && tnew[rs_addr] > rs_tuse. haz_rt is the same form using rt.
- full = dst_we && dst_addr!=0 && cnt[dst_addr]==MAX_INFLIGHT && !(wb_we && wb_addr==dst_addr).
- stall = issue_valid && (haz_rs || haz_rt || full).
- issue_fire = issue_valid && !stall.
- Each cycle, every tnew[r]!=0 decrements by 1, saturating at 0.
- On issue_fire && dst_we && dst_addr!=0: tnew[dst] <= dst_tnew, overriding the decrement. The youngest producer defines readiness.
- Counter update per register r:
  - +1 on issue_fire && dst_we && dst_addr==r && r!=0.
  - -1 on wb_we && wb_addr==r && r!=0 && cnt[r]!=0.
  - Both in the same cycle: cnt unchanged; tnew loaded.
  - Retire with cnt==0 is ignored (no underflow).
- Issue with dst==0 or dst_we=0: no state change.
- Reset mid-operation: all pending state is dropped. The pipeline is flushed by the same reset.
- busy_mask[r] = (cnt[r]!=0), registered state only.

Optional Feature:
- Macro: GRF_SB_PERF_EN.
- Defined: stall_cycles increments by 1 every cycle stall=1. Wraps at 2^32. Cleared by reset.
- Undefined: stall_cycles is tied to 32'b0 and no counter flops are synthesised. The port list is identical in both builds.

Decomposition:
- Shared package pipe_pkg: T_W, NREG, MAX_INFLIGHT, and Tuse/Tnew constants per instruction class (TUSE_BR=0, TUSE_ALU=1, TUSE_ST=2, TNEW_ALU=1, TNEW_LD=2, TNEW_LINK=0).
- One sub-module: sb_entry (cnt/tnew counter pair for one register), instantiated NREG-1 times via generate.

Test Plan:
- Load-use: issue dst=$8 tnew=2 at cycle 0, then rs=$8 tuse=1 at cycle 1 -> stall=1 at cycle 1, stall=0 and issue_fire=1 at cycle 2.
- Branch-after-ALU: dst=$3 tnew=1, next rs=$3 tuse=0 -> one stall cycle. Same case with tuse=1 -> no stall.
- Write-through: cnt[$5]=1, wb_we=1 wb_addr=$5 in the same cycle as issue rs=$5 tuse=0 with tnew[$5]=1 -> stall=0, and cnt[$5]=0 next cycle.
- Register 0: dst=$0 and rs=$0 in every combination -> never stall, busy_mask[0]=0 always.
- Saturation: three writes to $9 without retire, then a fourth issue dst=$9 -> stall=1 (full). With wb to $9 in that cycle -> fire, and cnt stays 3.
- Reset mid-hazard: stall=1 on $8, assert reset one cycle -> busy_mask=0, stall=0 next cycle. With GRF_SB_PERF_EN, stall_cycles returns to 0.
